// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Shift-add multiplier with its own control FSM. It accepts one operand pair at
// a time through a valid/ready handshake, shifts for N cycles, and then holds
// the 2N-bit product until the consumer takes it.
//
// Compile-time option:
//   MULTIPLIER_SIGNED_EN - when defined, i_signed_mode selects two's-complement
//                          operands for each operation. The operands are
//                          multiplied as magnitudes and the product is negated
//                          at the output when the signs differ. When the macro
//                          is undefined, every operation is unsigned and
//                          i_signed_mode is ignored.
//
// Parameters:
//   N               operand width in bits, legal range 2..32
//
// Ports:
//   i_clock         rising-edge clock
//   i_n_reset       asynchronous active-low reset
//   i_in_valid      an operand pair is offered
//   o_in_ready      block can accept operands (IDLE)
//   i_multiplicand  operand A, N bits
//   i_multiplier    operand B, N bits
//   i_signed_mode   1 = both operands are two's complement (signed build only)
//   o_out_valid     product is available (DONE)
//   i_out_ready     consumer takes the product
//   o_product       2N-bit result, stable while o_out_valid=1
//   o_busy          high while the block is shifting (SHIFT)
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int N = 4
) (
  input  logic           i_clock,
  input  logic           i_n_reset,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N-1:0]   i_multiplicand,
  input  logic [N-1:0]   i_multiplier,
  input  logic           i_signed_mode,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [2*N-1:0] o_product,
  output logic           o_busy
);

  // state | meaning
  // ------+-------------------------------------------------------------
  // IDLE  | waiting for operands; in_ready=1
  // SHIFT | one add/shift step per cycle, N cycles in total; busy=1
  // DONE  | product held until the consumer takes it; out_valid=1

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             w_load;
  logic             w_shift;

  logic [N-1:0]     r_mcand;
  logic             r_carry;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_lo;
  logic [CNT_W-1:0] r_count;

  logic [N-1:0]     w_a_mag;
  logic [N-1:0]     w_b_mag;
  logic             w_neg;
  logic [N:0]       w_sum;
  logic [2*N-1:0]   w_prod;
  logic             w_last_step;

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
`ifdef MULTIPLIER_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg;

  assign w_a_neg = i_signed_mode & i_multiplicand[N-1];
  assign w_b_neg = i_signed_mode & i_multiplier[N-1];

  // The most-negative value negates to itself, and read as unsigned that bit
  // pattern is exactly 2^(N-1). So the magnitude always fits in N bits.
  assign w_a_mag = w_a_neg ? -i_multiplicand : i_multiplicand;
  assign w_b_mag = w_b_neg ? -i_multiplier   : i_multiplier;

  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_neg <= 1'b0;
    end else if (w_load) begin
      r_neg <= w_a_neg ^ w_b_neg;
    end
  end

  assign w_neg = r_neg;
`else
  logic w_unused_signed_mode;

  assign w_a_mag              = i_multiplicand;
  assign w_b_mag              = i_multiplier;
  assign w_neg                = 1'b0;
  assign w_unused_signed_mode = i_signed_mode;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_last_step = (r_count == CNT_W'(N - 1));

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_busy       = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_load       = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        o_busy  = 1'b1;
        w_shift = 1'b1;
        if (w_last_step) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // r_carry is always 0 when a step starts. Including it here keeps the add
  // as a plain (N+1)-bit sum of the high half and the multiplicand.
  assign w_sum = r_lo[0] ? ({r_carry, r_hi} + {1'b0, r_mcand})
                         : {r_carry, r_hi};

  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_mcand <= '0;
      r_carry <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_mcand <= w_a_mag;
      r_carry <= 1'b0;
      r_hi    <= '0;
      r_lo    <= w_b_mag;
      r_count <= '0;
    end else if (w_shift) begin
      // Shift {carry, hi, lo} right by one. The carry becomes the top bit of
      // hi, and the bit shifted out of hi becomes the top bit of lo.
      r_carry <= 1'b0;
      r_hi    <= w_sum[N:1];
      r_lo    <= {w_sum[0], r_lo[N-1:1]};
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign w_prod    = {r_hi, r_lo};
  assign o_product = w_neg ? -w_prod : w_prod;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4, sm4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8, sm8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_pass  = 0;
  int n_total = 0;

  seq_multiplier #(.N(4)) u_mul4 (
    .i_clock        (clk),
    .i_n_reset      (rst_n),
    .i_in_valid     (in_valid4),
    .o_in_ready     (in_ready4),
    .i_multiplicand (a4),
    .i_multiplier   (b4),
    .i_signed_mode  (sm4),
    .o_out_valid    (out_valid4),
    .i_out_ready    (out_ready4),
    .o_product      (p4),
    .o_busy         (busy4)
  );

  seq_multiplier #(.N(8)) u_mul8 (
    .i_clock        (clk),
    .i_n_reset      (rst_n),
    .i_in_valid     (in_valid8),
    .o_in_ready     (in_ready8),
    .i_multiplicand (a8),
    .i_multiplier   (b8),
    .i_signed_mode  (sm8),
    .o_out_valid    (out_valid8),
    .i_out_ready    (out_ready8),
    .o_product      (p8),
    .o_busy         (busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Starts at a negedge with the N=4 block idle, ends at a negedge back in IDLE.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                     input logic [7:0] exp, input string tag);
    int lat;
    a4 = a; b4 = b; sm4 = sm; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_prod"}, 32'(p4), 32'(exp));
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk({tag, "_rdy"}, 32'(in_ready4), 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string tag);
    int lat;
    a8 = a; b8 = b; sm8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_prod"}, 32'(p8), 32'(exp));
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk({tag, "_rdy"}, 32'(in_ready8), 32'd1);
  endtask

  initial begin
    int acc[$];
    int overlap;
    int w;

    rst_n = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 32'(in_ready4), 32'd1);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_prod4", 32'(p4), 32'd0);
    chk("rst_prod8", 32'(p8), 32'd0);
    chk("rst_in_ready8", 32'(in_ready8), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Worked example 11 x 6, step by step
    a4 = 4'd11; b4 = 4'd6; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    chk("trace0", 32'(p4), 32'h06);
    chk("trace0_busy", 32'(busy4), 32'd1);
    chk("trace0_in_ready", 32'(in_ready4), 32'd0);
    @(negedge clk);
    chk("trace1", 32'(p4), 32'h03);
    chk("trace1_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    chk("trace2", 32'(p4), 32'h59);
    chk("trace2_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    chk("trace3", 32'(p4), 32'h84);
    chk("trace3_busy", 32'(busy4), 32'd1);
    chk("trace3_out_valid", 32'(out_valid4), 32'd0);
    @(negedge clk);
    chk("trace4_prod", 32'(p4), 32'd66);
    chk("trace4_out_valid", 32'(out_valid4), 32'd1);
    chk("trace4_busy", 32'(busy4), 32'd0);
    chk("trace4_in_ready", 32'(in_ready4), 32'd0);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("handoff_in_ready", 32'(in_ready4), 32'd1);
    chk("handoff_out_valid", 32'(out_valid4), 32'd0);

    op4(4'd15, 4'd15, 1'b0, 8'd225, "u15x15");

`ifdef MULTIPLIER_SIGNED_EN
    op4(4'hB, 4'd6, 1'b1, 8'hE2, "s_m5x6");
    op4(4'h8, 4'h8, 1'b1, 8'h40, "s_m8xm8");
    op4(4'd7, 4'hF, 1'b1, 8'hF9, "s_7xm1");
    op4(4'hB, 4'd6, 1'b0, 8'd66, "s_off_11x6");
`else
    // signed_mode has no effect in the unsigned build
    op4(4'hB, 4'd6, 1'b1, 8'd66, "sm_ign_11x6");
    op4(4'd7, 4'hF, 1'b1, 8'd105, "sm_ign_7x15");
`endif
    sm4 = 1'b0;

    // Backpressure: product held, new operands ignored
    a4 = 4'd3; b4 = 4'd4; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    w = 0;
    while (!out_valid4 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_lat", 32'(w), 32'd4);
    a4 = 4'd15; b4 = 4'd15; in_valid4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_prod", 32'(p4), 32'h0C);
      chk("bp_out_valid", 32'(out_valid4), 32'd1);
      chk("bp_in_ready", 32'(in_ready4), 32'd0);
      @(negedge clk);
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready4), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid4), 32'd0);

    // Reset in the middle of SHIFT
    a4 = 4'd5; b4 = 4'd7; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_prod", 32'(p4), 32'd0);
    chk("midrst_out_valid", 32'(out_valid4), 32'd0);
    chk("midrst_in_ready", 32'(in_ready4), 32'd1);
    chk("midrst_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op4(4'd3, 4'd5, 1'b0, 8'd15, "after_rst_3x5");

    // Zero operand still takes N cycles
    op4(4'd0, 4'd9, 1'b0, 8'd0, "zero_0x9");

    // Back-to-back accepts with in_valid held high
    a4 = 4'd2; b4 = 4'd3; in_valid4 = 1'b1; out_ready4 = 1'b1;
    overlap = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_ready4) acc.push_back(cyc);
      if (in_ready4 && out_valid4) overlap++;
      if (out_valid4) chk("b2b_prod", 32'(p4), 32'd6);
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    repeat (8) @(negedge clk);
    out_ready4 = 1'b0;
    chk("b2b_overlap", 32'(overlap), 32'd0);
    chk("b2b_accepts", 32'(acc.size() >= 3), 32'd1);
    if (acc.size() >= 3) begin
      chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd6);
      chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd6);
    end

    // N=8 instance
    op8(8'd255, 8'd255, 16'hFE01, "n8_255x255");
    op8(8'd200, 8'd3, 16'd600, "n8_200x3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Self-contained, parametrised shift-add multiplier: an N-bit datapath plus its own control FSM behind valid/ready handshakes on both operand and result sides. One operand pair is accepted at a time. The block takes N shift cycles and holds the 2N-bit product until the consumer takes it. Two's-complement operands are supported when the signed feature is compiled in. It replaces the separately sequenced datapath/controller pair wherever a multiply unit is needed.

## Interface
- N, default 4: operand width in bits; legal range 2..32.
- clock  input  1  rising-edge clock.
- n_reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands.
- multiplicand  input  N  operand A.
- multiplier  input  N  operand B.
- signed_mode  input  1  sampled with operands; 1 = both operands two's complement (ignored unless MULTIPLIER_SIGNED_EN).
- out_valid  output  1  product available.
- out_ready  input  1  consumer takes product.
- product  output  2N  result; stable while out_valid=1.
- busy  output  1  high in SHIFT state.

## Operation
- Internal state: mcand register (N bits), product register {carry, hi[N-1:0], lo[N-1:0]}, step counter of width clog2(N+1), neg flag.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, perform the following load and go to SHIFT:
  - mcand <= |multiplicand|; lo <= |multiplier|; hi, carry, count <= 0.
  - neg <= sign(A) xor sign(B), in signed mode only.
  - Magnitude applies only in signed mode. Otherwise operands load unchanged.
- SHIFT, each cycle:
  - If lo[0], then {carry, hi} <= hi + mcand (N+1-bit sum).
  - Then shift the whole {carry, hi, lo} right by one; carry <= 0.
  - count increments. After the N-th shift, go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE. Otherwise hold the product indefinitely.
- product output:
  - {hi, lo} when neg=0.
  - Two's-complement negation of {hi, lo} when neg=1. This is combinational from registers, so it adds no latency.
- Worked example, N=4, A=11, B=6: {hi, lo} goes 0000_0110 → 0000_0011 → 0101_1001 → 1000_0100 → 0100_0010 (66).
- Edge cases:
  - Most-negative operand: -2^(N-1) has magnitude 2^(N-1), which fits in N unsigned bits, so the result is exact.
  - (-2^(N-1))² = 2^(2N-2) is representable.
  - A or B = 0 still takes N shift cycles; there is no early exit.
- Inputs are ignored outside IDLE. Operand changes while busy do not affect the running result.

## Timing
- Reset values, applied asynchronously while n_reset=0:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - product=0; all internal registers 0.
- Accept edge E (in_valid & in_ready). Shifts occur on edges E+1..E+N. out_valid rises after edge E+N.
- Latency from accept to out_valid is N cycles.
- Product hands off on the first edge where out_valid & out_ready. in_ready rises after that edge.
- Minimum initiation interval is N+2 cycles: one IDLE cycle, N SHIFT cycles, one DONE cycle.
- in_ready and out_valid are never high in the same cycle.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE; the product is lost and out_valid=0.

## Configuration
- MULTIPLIER_SIGNED_EN defined:
  - Magnitude conversion, neg flag and output negation are compiled in.
  - signed_mode selects signed or unsigned per operation.
- Not defined:
  - signed_mode is ignored and neg is tied to 0; every operation is unsigned.
  - Latency and handshake are unchanged.

## Test plan
- N=4, unsigned, A=11, B=6: in_valid one cycle. Required response:
  - busy for 4 cycles.
  - {hi, lo} trace 0x06, 0x03, 0x59, 0x84, then product=8'd66 with out_valid at accept+4.
- N=4, unsigned, A=15, B=15 → product=8'd225. N=8, unsigned, A=255, B=255 → product=16'hFE01.
- MULTIPLIER_SIGNED_EN, N=4, signed_mode=1:
  - A=-5, B=6 → product=8'hE2 (-30).
  - A=-8, B=-8 → product=8'h40.
  - A=7, B=-1 → product=8'hF9.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required response:
  - product and out_valid stay stable; in_ready=0.
  - New operands offered during this time are ignored.
  - out_ready=1 → IDLE on the next cycle.
- Reset: assert n_reset=0 at accept+2. Required response:
  - Immediately product=0, out_valid=0, in_ready=1.
  - After release, A=3, B=5 → product=8'd15 in 4 cycles.
- Zero operand: A=0, B=9 → product=0, still after exactly N cycles. Back-to-back ops with in_valid held high → accepts spaced exactly N+2 cycles apart.
